cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run/step controller for the pipelined MIPS CPU board build. Converts raw board switches into a clean, single-clock-domain execution schedule: synchronises and debounces the switches, selects one of four execution rates, and issues one-cycle `cpu_en` clock-enable pulses to the CPU instead of a divided clock. Also sequences a timed soft reset and parks the CPU on a halt request. Sits between the switch pins and the CPU/display top level.

## Interface
- `DIV`, 16: base prescaler period in `clk` cycles (rate 0). Must be a multiple of 8 and at least 16.
- `DEB_CYCLES`, 500000: consecutive stable cycles required to accept a switch change. Must be at least 2.
- `RST_CYCLES`, 4: minimum number of `cpu_rst` cycles per reset.
- `clk`, in, 1: system clock. All logic is on its rising edge.
- `rst`, in, 1: reset. Asynchronous assertion, active-low.
- `sw_go`, in, 1: raw run/pause level. 1 = run.
- `sw_step`, in, 1: raw single-step request. Acts on its rising edge.
- `sw_rate`, in, 1: raw rate-cycle request. Acts on its rising edge.
- `sw_clr`, in, 1: raw soft-reset request. Acts on its rising edge; its level extends the reset.
- `cpu_halt`, in, 1: synchronous level from the CPU (halt/syscall retired).
- `cpu_en`, out, 1: registered one-cycle CPU clock-enable pulse.
- `cpu_rst`, out, 1: active-high reset to the CPU.
- `rate_sel`, out, 2: current rate index. Period = `DIV >> rate_sel`.
- `run_state`, out, 2: FSM state. 00 RESET, 01 PAUSE, 10 RUN, 11 HALT.
- `en_count`, out, 16: number of `cpu_en` pulses issued since the last reset.

## Operation
- **Input conditioning**
  - Each raw switch passes through a 2-flop synchroniser, then a debouncer.
  - The debouncer counter runs while the synced value differs from the debounced value; it clears whenever they are equal.
  - When the synced value has differed for `DEB_CYCLES` consecutive cycles, the debounced value flips.
  - `*_rise` = debounced & ~previous debounced. This gives one pulse per accepted 0→1 transition.
- **Rate**
  - `rate_sel` increments mod 4 on `rate_rise`, in any state (3→0 wraps).
  - `rate_sel` is cleared only by `rst`; a soft reset does not change it.
- **Prescaler**
  - `pcnt` counts 0..T-1 with T = `DIV >> rate_sel`.
  - `tick` is asserted when `pcnt == T-1`; `pcnt` then returns to 0.
  - `pcnt` is forced to 0 in RESET and in the cycle following a `rate_rise`.
- **FSM transitions.** Priority order: `clr_rise`, then `cpu_halt`, then go/step.
  - Any state, on `clr_rise`: go to RESET.
  - RESET: stay while `rcnt < RST_CYCLES-1` or debounced `sw_clr` = 1. Otherwise go to PAUSE.
  - PAUSE: if `go_deb` = 1, go to RUN.
  - RUN: if `cpu_halt` = 1, go to HALT. Otherwise, if `go_deb` = 0, go to PAUSE.
  - HALT: if `go_deb` = 0, go to PAUSE. Re-entering RUN therefore requires toggling go low then high.
- **Outputs** (next-cycle values, computed from the current state)
  - `cpu_en` <= (RUN & `tick` & !`cpu_halt`) | (PAUSE & `step_rise` & !`cpu_halt`).
  - `cpu_rst` = (state == RESET).
  - `rcnt` clears on entry to RESET and saturates at `RST_CYCLES-1`.
  - `en_count` increments on each `cpu_en` pulse, wraps 0xFFFF→0, and is held at 0 in RESET.
- A `step_rise` in RUN or HALT is ignored. A `tick` in PAUSE or HALT is ignored.

## Timing
- **Reset values** (while `rst` = 0): `cpu_en` 0, `cpu_rst` 1, `rate_sel` 0, `run_state` 00, `en_count` 0, all synchronisers, debouncers and counters 0.
- **After `rst` release:** `cpu_rst` stays high for exactly `RST_CYCLES` cycles, then PAUSE.
- **Switch latency:** raw edge to debounced flip is 2 + `DEB_CYCLES` cycles. A glitch shorter than `DEB_CYCLES` synced cycles produces no change.
- **Step latency:** `step_rise` to `cpu_en` is 1 cycle. `cpu_en` is always exactly 1 cycle wide.
- **Run entry:** first `cpu_en` within T+1 cycles of entering RUN. Thereafter pulses are spaced exactly T cycles while `rate_sel` is constant.
- **Halt:** `cpu_halt` asserted in RUN suppresses any `cpu_en` in the same cycle. HALT is entered on the next edge.
- **Soft reset mid-run:** a `cpu_en` already registered completes. No further pulses are issued. `cpu_rst` rises 1 cycle after `clr_rise`.

## Test plan
All scenarios use `DIV`=16, `DEB_CYCLES`=4, `RST_CYCLES`=4.
1. Reset: hold `rst`=0 for 3 cycles, release with all switches 0 → `cpu_rst`=1 for 4 cycles after release, then `run_state`=01; `cpu_en` never asserts; `en_count`=0.
2. Run at rate 0: set `sw_go`=1 → RUN 6–7 cycles later; `cpu_en` pulses exactly every 16 cycles; 160 cycles after the first pulse, `en_count`=11.
3. Rate cycling: four `sw_rate` pulses, each held 10 cycles, in RUN → `rate_sel` steps 1, 2, 3, 0; measured `cpu_en` periods are 8, 4, 2, 16.
4. Step and debounce: in PAUSE, a 2-cycle `sw_step` glitch → no `cpu_en`; then a 10-cycle `sw_step` pulse → exactly one `cpu_en`, `en_count` +1.
5. Halt: in RUN, assert `cpu_halt` → `run_state`=11 and no further `cpu_en`; drop `sw_go` → 01; raise `sw_go` again → 10, pulses resume.
6. Soft reset: in RUN at `rate_sel`=2, `sw_clr` high for 10 cycles → `cpu_rst` high until the debounced clear drops, `en_count`=0, `rate_sel` stays 2; with `sw_go`=1, PAUSE is followed by RUN on the next cycle.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step controller for the pipelined MIPS CPU board build.
// Turns raw board switches into a single-clock execution schedule. It
// synchronises and debounces the switches, selects one of four execution
// rates, and issues one-cycle cpu_en clock-enable pulses instead of a divided
// clock. It also sequences a timed soft reset and parks the CPU while it
// reports a halt.
module cpu_run_ctrl #(
    parameter int DIV        = 16,
    parameter int DEB_CYCLES = 500000,
    parameter int RST_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sw_go,
    input  logic        sw_step,
    input  logic        sw_rate,
    input  logic        sw_clr,
    input  logic        cpu_halt,
    output logic        cpu_en,
    output logic        cpu_rst,
    output logic [1:0]  rate_sel,
    output logic [1:0]  run_state,
    output logic [15:0] en_count
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int PW = $clog2(DIV + 1);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] RCNT_LAST = RW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_PAUSE = 2'b01,
        ST_RUN   = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    // Switch lanes: 0 go, 1 step, 2 rate, 3 clr
    logic [3:0]    sw_raw;
    logic [3:0]    sync_p0;
    logic [3:0]    sync_p1;
    logic [3:0]    deb;
    logic [3:0]    deb_q;
    logic [3:0]    rise;
    logic [CW-1:0] deb_cnt [4];

    logic go_deb;
    logic clr_deb;
    logic step_rise;
    logic rate_rise;
    logic clr_rise;

    logic [PW-1:0] period;
    logic [PW-1:0] pcnt;
    logic          tick;

    state_t        state;
    state_t        state_nxt;
    logic [RW-1:0] rcnt;

    assign sw_raw = {sw_clr, sw_rate, sw_step, sw_go};

    // Two-flop synchroniser for every raw switch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= sw_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Debouncer: accept a new level only after DEB_CYCLES consecutive differing cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            deb_q <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync_p1[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise      = deb & ~deb_q;
    assign go_deb    = deb[0];
    assign clr_deb   = deb[3];
    assign step_rise = rise[1];
    assign rate_rise = rise[2];
    assign clr_rise  = rise[3];

    // Rate index survives soft resets; only the board reset clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rate_sel <= 2'd0;
        end else if (rate_rise) begin
            rate_sel <= rate_sel + 2'd1;
        end
    end

    assign period = PW'(DIV >> rate_sel);
    assign tick   = (pcnt == period - 1'b1);

    // Prescaler restarts on reset and on every rate change so the new period starts clean
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
        end else if (state == ST_RESET || rate_rise || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: soft clear beats halt, halt beats go
    always_comb begin
        state_nxt = state;
        if (clr_rise) begin
            state_nxt = ST_RESET;
        end else begin
            case (state)
                ST_RESET: if (rcnt == RCNT_LAST && !clr_deb) state_nxt = ST_PAUSE;
                ST_PAUSE: if (go_deb) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (cpu_halt) begin
                        state_nxt = ST_HALT;
                    end else if (!go_deb) begin
                        state_nxt = ST_PAUSE;
                    end
                end
                ST_HALT:  if (!go_deb) state_nxt = ST_PAUSE;
                default:  state_nxt = ST_RESET;
            endcase
        end
    end

    // Reset-length counter: zero outside RESET, saturates at RST_CYCLES-1 inside
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt <= '0;
        end else if (state != ST_RESET || clr_rise) begin
            rcnt <= '0;
        end else if (rcnt != RCNT_LAST) begin
            rcnt <= rcnt + 1'b1;
        end
    end

    // Registered clock-enable: prescaler ticks in RUN, step edges in PAUSE, never while halting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_en <= 1'b0;
        end else begin
            cpu_en <= ((state == ST_RUN && tick) || (state == ST_PAUSE && step_rise)) && !cpu_halt;
        end
    end

    // Pulse counter, held at zero while the CPU is in reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_count <= 16'd0;
        end else if (state == ST_RESET) begin
            en_count <= 16'd0;
        end else if (cpu_en) begin
            en_count <= en_count + 16'd1;
        end
    end

    assign cpu_rst   = (state == ST_RESET);
    assign run_state = state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: cycle model of the switch/run schedule plus
// directed scenarios with hand-computed expectations.
module tb_cpu_run_ctrl;

    localparam int DIV  = 16;
    localparam int DEB  = 4;
    localparam int RSTC = 4;

    localparam int S_RESET = 0;
    localparam int S_PAUSE = 1;
    localparam int S_RUN   = 2;
    localparam int S_HALT  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sw_go = 1'b0;
    logic        sw_step = 1'b0;
    logic        sw_rate = 1'b0;
    logic        sw_clr = 1'b0;
    logic        cpu_halt = 1'b0;
    logic        cpu_en;
    logic        cpu_rst;
    logic [1:0]  rate_sel;
    logic [1:0]  run_state;
    logic [15:0] en_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pulses[$];

    cpu_run_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB), .RST_CYCLES(RSTC)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .sw_go     (sw_go),
        .sw_step   (sw_step),
        .sw_rate   (sw_rate),
        .sw_clr    (sw_clr),
        .cpu_halt  (cpu_halt),
        .cpu_en    (cpu_en),
        .cpu_rst   (cpu_rst),
        .rate_sel  (rate_sel),
        .run_state (run_state),
        .en_count  (en_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step_cyc();
        @(negedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    int m_st, m_rate, m_phase, m_age, m_cnt;
    bit m_en;
    bit m_deb [4];
    bit m_prev [4];
    bit m_d1 [4];
    bit m_d2 [4];
    int m_run [4];

    always @(posedge clk or negedge rst_n) begin : model
        bit rise [4];
        bit sw [4];
        bit tick;
        int per;
        int nst;
        if (!rst_n) begin
            m_st <= S_RESET; m_rate <= 0; m_phase <= 0; m_age <= 0; m_cnt <= 0; m_en <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_deb[i] <= 1'b0; m_prev[i] <= 1'b0; m_d1[i] <= 1'b0; m_d2[i] <= 1'b0; m_run[i] <= 0;
            end
        end else begin
            sw[0] = sw_go; sw[1] = sw_step; sw[2] = sw_rate; sw[3] = sw_clr;
            for (int i = 0; i < 4; i++) rise[i] = m_deb[i] && !m_prev[i];
            per  = DIV >> m_rate;
            tick = ((m_phase % per) == per - 1);
            m_en  <= ((m_st == S_RUN && tick) || (m_st == S_PAUSE && rise[1])) && !cpu_halt;
            m_cnt <= (m_st == S_RESET) ? 0 : (m_en ? (m_cnt + 1) % 65536 : m_cnt);
            nst = m_st;
            if (rise[3]) nst = S_RESET;
            else if (m_st == S_RESET) begin
                if (m_age >= RSTC - 1 && !m_deb[3]) nst = S_PAUSE;
            end else if (m_st == S_PAUSE) begin
                if (m_deb[0]) nst = S_RUN;
            end else if (m_st == S_RUN) begin
                if (cpu_halt) nst = S_HALT;
                else if (!m_deb[0]) nst = S_PAUSE;
            end else begin
                if (!m_deb[0]) nst = S_PAUSE;
            end
            m_st    <= nst;
            m_age   <= (m_st == S_RESET && !rise[3]) ? m_age + 1 : 0;
            m_phase <= (m_st == S_RESET || rise[2]) ? 0 : m_phase + 1;
            m_rate  <= rise[2] ? (m_rate + 1) % 4 : m_rate;
            for (int i = 0; i < 4; i++) begin
                m_prev[i] <= m_deb[i];
                m_d1[i]   <= sw[i];
                m_d2[i]   <= m_d1[i];
                if (m_d2[i] == m_deb[i]) m_run[i] <= 0;
                else if (m_run[i] + 1 >= DEB) begin
                    m_deb[i] <= m_d2[i];
                    m_run[i] <= 0;
                end else m_run[i] <= m_run[i] + 1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        check("cpu_en",    int'(cpu_en),    int'(m_en));
        check("cpu_rst",   int'(cpu_rst),   int'(m_st == S_RESET));
        check("rate_sel",  int'(rate_sel),  m_rate);
        check("run_state", int'(run_state), m_st);
        check("en_count",  int'(en_count),  m_cnt);
    end

    // Pulse timestamp collector
    always @(negedge clk) if (cpu_en) pulses.push_back(cyc);

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int n, lat, c0, entry, first, base, ec, per;
        int st [26];
        bit rh [26];
        int exp_rate [4];
        int exp_per [4];
        exp_rate = '{1, 2, 3, 0};
        exp_per  = '{8, 4, 2, 16};

        // 1. reset
        #1 rst_n = 1'b0;
        repeat (3) step_cyc();
        check("rst_cpu_rst", int'(cpu_rst), 1);
        check("rst_state", int'(run_state), 0);
        check("rst_en_count", int'(en_count), 0);
        check("rst_rate", int'(rate_sel), 0);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (cpu_rst) n++;
            step_cyc();
        end
        check("rst_release_cycles", n, 4);
        check("pause_after_rst", int'(run_state), 1);
        check("no_en_after_rst", pulses.size(), 0);

        // 2. run at rate 0
        c0 = cyc; sw_go = 1'b1; lat = -1;
        for (int k = 0; k < 12 && lat < 0; k++) begin
            step_cyc();
            if (run_state == 2'd2) lat = cyc - c0;
        end
        check("run_entry_latency", lat, 7);
        entry = cyc;
        pulses.delete();
        for (int k = 0; k < 40 && pulses.size() == 0; k++) step_cyc();
        first = (pulses.size() > 0) ? pulses[0] : -1000;
        check("first_en_within_T+1", int'(first - entry >= 0 && first - entry <= DIV + 1), 1);
        if (first < 0) first = cyc;
        while (cyc < first + 161) step_cyc();
        check("en_count_after_160", int'(en_count), 11);
        check("pulses_after_160", pulses.size(), 11);
        for (int i = 1; i < pulses.size(); i++) check("period_rate0", pulses[i] - pulses[i-1], 16);

        // 3. rate cycling
        for (int r = 0; r < 4; r++) begin
            sw_rate = 1'b1;
            repeat (10) step_cyc();
            sw_rate = 1'b0;
            repeat (10) step_cyc();
            check("rate_step", int'(rate_sel), exp_rate[r]);
            pulses.delete();
            repeat (40) step_cyc();
            per = (pulses.size() >= 2) ? pulses[1] - pulses[0] : -1;
            check("rate_period", per, exp_per[r]);
        end

        // 4. step and debounce
        sw_go = 1'b0;
        repeat (10) step_cyc();
        check("pause_for_step", int'(run_state), 1);
        base = en_count;
        pulses.delete();
        sw_step = 1'b1;
        repeat (2) step_cyc();
        sw_step = 1'b0;
        repeat (15) step_cyc();
        check("step_glitch_no_en", pulses.size(), 0);
        sw_step = 1'b1;
        repeat (10) step_cyc();
        sw_step = 1'b0;
        repeat (15) step_cyc();
        check("step_one_en", pulses.size(), 1);
        check("step_en_count", int'(en_count), base + 1);

        // 5. halt
        sw_go = 1'b1;
        repeat (10) step_cyc();
        check("run_before_halt", int'(run_state), 2);
        repeat (20) step_cyc();
        cpu_halt = 1'b1;
        step_cyc();
        check("halt_state", int'(run_state), 3);
        pulses.delete();
        repeat (30) step_cyc();
        check("halt_no_en", pulses.size(), 0);
        cpu_halt = 1'b0;
        repeat (5) step_cyc();
        check("halt_held_go_high", int'(run_state), 3);
        sw_go = 1'b0;
        repeat (10) step_cyc();
        check("halt_to_pause", int'(run_state), 1);
        sw_go = 1'b1;
        repeat (10) step_cyc();
        check("pause_to_run", int'(run_state), 2);
        pulses.delete();
        repeat (40) step_cyc();
        check("pulses_resume", int'(pulses.size() >= 2), 1);

        // 6. soft reset at rate 2
        for (int r = 0; r < 2; r++) begin
            sw_rate = 1'b1;
            repeat (10) step_cyc();
            sw_rate = 1'b0;
            repeat (10) step_cyc();
        end
        check("rate_before_clr", int'(rate_sel), 2);
        repeat (10) step_cyc();
        sw_clr = 1'b1;
        ec = -1;
        for (int k = 1; k <= 25; k++) begin
            step_cyc();
            st[k] = run_state;
            rh[k] = cpu_rst;
            if (k == 7) pulses.delete();
            if (k == 8) ec = en_count;
            if (k == 10) sw_clr = 1'b0;
            if (k == 16) check("clr_no_en_in_reset", pulses.size(), 0);
        end
        n = 0;
        for (int k = 1; k <= 25; k++) if (rh[k]) n++;
        check("clr_still_run", st[6], 2);
        check("clr_reset_entry", st[7], 0);
        check("clr_reset_held", st[16], 0);
        check("clr_pause", st[17], 1);
        check("clr_run_next", st[18], 2);
        check("clr_rst_cycles", n, 10);
        check("clr_en_count_zero", ec, 0);
        check("clr_rate_kept", int'(rate_sel), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
